// File: rtl/vec_magnitude_iter.sv
`default_nettype none
// ============================================================================
// Module      : vec_magnitude_iter
// Description : Multi-cycle Euclidean magnitude engine.
//               out_mag = floor(sqrt(sum ch[i]^2)) over NUM_CH channels.
//               One channel is squared per cycle, then a bit-serial restoring
//               square root produces one result bit per cycle.
//               Optional round-to-nearest stage when VEC_MAG_ROUND_EN is
//               defined (adds one RND cycle of latency).
// Ports       : clk, rst (async, active-high), ena (global advance enable)
//               in_valid / in_ready / in_data   - input handshake + channels
//               out_valid / out_ready           - output handshake
//               out_mag (DATA_W+1), out_sumsq (2*DATA_W+2) - results
// Revision    : 1.0 - initial release
// ============================================================================
module vec_magnitude_iter #(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 2,
    parameter int SIGNED_IN = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W:0]          out_mag,
    output logic [2*DATA_W+1:0]      out_sumsq
);

    localparam int c_SUM_W = 2 * DATA_W + 2;
    localparam int c_OUT_W = DATA_W + 1;
    localparam int c_CMP_W = c_SUM_W + 2;
    localparam int c_IN_W  = NUM_CH * DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SQ   = 3'd1,
        ST_ROOT = 3'd2,
        ST_RND  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IN_W-1:0]    r_data;
    logic [c_SUM_W-1:0]   r_acc;
    logic [2:0]           r_cnt;
    logic [c_OUT_W-1:0]   r_root;
    logic [c_OUT_W-1:0]   r_mask;
    logic [c_OUT_W-1:0]   r_mag;
    logic [c_SUM_W-1:0]   r_sumsq;

    logic                 w_accept;
    logic [DATA_W-1:0]    w_ch;
    logic [2*DATA_W-1:0]  w_ch_ext;
    logic [2*DATA_W-1:0]  w_sq;
    logic [c_OUT_W-1:0]   w_t;
    logic [c_CMP_W-1:0]   w_t_ext;
    logic [c_CMP_W-1:0]   w_tt;
    logic [c_CMP_W-1:0]   w_acc_ext;
    logic [c_OUT_W-1:0]   w_root_nxt;

    assign in_ready  = (r_state == ST_IDLE) & ena & ~rst;
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign out_mag   = r_mag;
    assign out_sumsq = r_sumsq;

    // Channels are shifted down as they are consumed, so the active one is
    // always in the low slot. Sign extension to 2*DATA_W makes the modular
    // product equal the true square (which always fits 2*DATA_W bits).
    assign w_ch     = r_data[DATA_W-1:0];
    assign w_ch_ext = (SIGNED_IN != 0) ? {{DATA_W{w_ch[DATA_W-1]}}, w_ch}
                                       : {{DATA_W{1'b0}}, w_ch};
    assign w_sq     = w_ch_ext * w_ch_ext;

    // Restoring root step: try setting the current bit, keep it if t^2 <= acc.
    assign w_t        = r_root | r_mask;
    assign w_t_ext    = {{(c_CMP_W - c_OUT_W){1'b0}}, w_t};
    assign w_tt       = w_t_ext * w_t_ext;
    assign w_acc_ext  = {2'b00, r_acc};
    assign w_root_nxt = (w_tt <= w_acc_ext) ? w_t : r_root;

`ifdef VEC_MAG_ROUND_EN
    logic [c_CMP_W-1:0] w_r_ext;
    logic [c_CMP_W-1:0] w_rr;
    logic [c_CMP_W-1:0] w_rem;
    logic               w_round_up;

    // Remainder above r means sqrt(acc) >= r + 0.5, so round up.
    assign w_r_ext    = {{(c_CMP_W - c_OUT_W){1'b0}}, r_root};
    assign w_rr       = w_r_ext * w_r_ext;
    assign w_rem      = w_acc_ext - w_rr;
    assign w_round_up = (w_rem > w_r_ext);
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (ena) begin
            case (r_state)
                ST_IDLE: if (w_accept) w_state_nxt = ST_SQ;
                ST_SQ:   if (r_cnt == 3'(NUM_CH - 1)) w_state_nxt = ST_ROOT;
                ST_ROOT: begin
                    if (r_mask[0]) begin
`ifdef VEC_MAG_ROUND_EN
                        w_state_nxt = ST_RND;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end
                end
                ST_RND:  w_state_nxt = ST_DONE;
                ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_root  <= '0;
            r_mask  <= '0;
            r_mag   <= '0;
            r_sumsq <= '0;
        end else if (ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data <= in_data;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                ST_SQ: begin
                    r_acc  <= r_acc + {2'b00, w_sq};
                    r_data <= r_data >> DATA_W;
                    r_cnt  <= r_cnt + 3'd1;
                    r_root <= '0;
                    r_mask <= {1'b1, {(c_OUT_W - 1){1'b0}}};
                end
                ST_ROOT: begin
                    r_root <= w_root_nxt;
                    r_mask <= r_mask >> 1;
`ifndef VEC_MAG_ROUND_EN
                    if (r_mask[0]) begin
                        r_mag   <= w_root_nxt;
                        r_sumsq <= r_acc;
                    end
`endif
                end
`ifdef VEC_MAG_ROUND_EN
                ST_RND: begin
                    r_mag   <= r_root + {{(c_OUT_W - 1){1'b0}}, w_round_up};
                    r_sumsq <= r_acc;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_magnitude_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_magnitude_iter
// Description : Randomised self-checking bench for vec_magnitude_iter.
//               Instance A: DATA_W=8, NUM_CH=2, unsigned.
//               Instance B: DATA_W=8, NUM_CH=4, signed.
//               Expected magnitudes come from integer arithmetic on the
//               decoded channel values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_magnitude_iter;

`ifdef VEC_MAG_ROUND_EN
    localparam int c_RND_LAT = 1;
`else
    localparam int c_RND_LAT = 0;
`endif
    localparam int c_OUT_W = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;

    logic        cur_sel;
    logic        in_valid_v;
    logic [31:0] in_data_v;
    logic        out_ready_v;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [8:0]  a_out_mag;
    logic [17:0] a_out_sumsq;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [8:0]  b_out_mag;
    logic [17:0] b_out_sumsq;

    logic        cur_in_ready, cur_out_valid;
    logic [31:0] cur_mag, cur_sumsq;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign a_in_valid  = in_valid_v  & ~cur_sel;
    assign b_in_valid  = in_valid_v  &  cur_sel;
    assign a_out_ready = out_ready_v & ~cur_sel;
    assign b_out_ready = out_ready_v &  cur_sel;

    assign cur_in_ready  = cur_sel ? b_in_ready  : a_in_ready;
    assign cur_out_valid = cur_sel ? b_out_valid : a_out_valid;
    assign cur_mag       = cur_sel ? 32'(b_out_mag)   : 32'(a_out_mag);
    assign cur_sumsq     = cur_sel ? 32'(b_out_sumsq) : 32'(a_out_sumsq);

    vec_magnitude_iter #(.DATA_W(8), .NUM_CH(2), .SIGNED_IN(0)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data_v[15:0]),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_mag   (a_out_mag),
        .out_sumsq (a_out_sumsq)
    );

    vec_magnitude_iter #(.DATA_W(8), .NUM_CH(4), .SIGNED_IN(1)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data_v),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_mag   (b_out_mag),
        .out_sumsq (b_out_sumsq)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: decode channels, sum squares, integer sqrt by search.
    task automatic model(input logic sel, input logic [31:0] data, output int sum, output int mag);
        int         nch;
        int         v;
        logic [7:0] b;
        nch = sel ? 4 : 2;
        sum = 0;
        for (int i = 0; i < nch; i++) begin
            b = data[i*8 +: 8];
            v = sel ? int'($signed(b)) : int'(b);
            sum += v * v;
        end
        mag = 0;
        while ((mag + 1) * (mag + 1) <= sum) mag++;
`ifdef VEC_MAG_ROUND_EN
        if (sum - mag * mag > mag) mag++;
`endif
    endtask

    // One full transaction: accept, wait for result (optionally with an
    // ena=0 gap mid-ROOT), hold back-pressure, then drain.
    task automatic run_vec(input logic sel, input logic [31:0] data, input int hold, input int gaps);
        int exp_sum, exp_mag, exp_lat, nch, c;
        model(sel, data, exp_sum, exp_mag);
        nch     = sel ? 4 : 2;
        exp_lat = nch + c_OUT_W + c_RND_LAT + gaps;
        @(negedge clk);
        cur_sel    = sel;
        in_data_v  = data;
        in_valid_v = 1'b1;
        c = 0;
        while (!cur_in_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        check_eq("in_ready_idle", 32'(cur_in_ready), 32'd1);
        @(negedge clk);
        in_valid_v = 1'b0;
        c = 0;
        while (!cur_out_valid && c < 200) begin
            if (gaps > 0 && c == nch + 2) begin
                ena = 1'b0;
                repeat (gaps) begin
                    @(negedge clk);
                    c++;
                end
                ena = 1'b1;
            end else begin
                @(negedge clk);
                c++;
            end
        end
        check_eq("latency", 32'(c), 32'(exp_lat));
        check_eq("out_mag", cur_mag, 32'(exp_mag));
        check_eq("out_sumsq", cur_sumsq, 32'(exp_sum));
        check_eq("in_ready_busy", 32'(cur_in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(cur_out_valid), 32'd1);
            check_eq("hold_mag", cur_mag, 32'(exp_mag));
            check_eq("hold_sumsq", cur_sumsq, 32'(exp_sum));
            check_eq("hold_in_ready", 32'(cur_in_ready), 32'd0);
        end
        out_ready_v = 1'b1;
        @(negedge clk);
        out_ready_v = 1'b0;
        check_eq("drained", 32'(cur_out_valid), 32'd0);
        check_eq("kept_mag", cur_mag, 32'(exp_mag));
    endtask

    initial begin
        int nch_r;
        rst         = 1'b1;
        ena         = 1'b1;
        cur_sel     = 1'b0;
        in_valid_v  = 1'b0;
        in_data_v   = '0;
        out_ready_v = 1'b0;
        #1;
        check_eq("rst_in_ready_a", 32'(a_in_ready), 32'd0);
        check_eq("rst_valid_a", 32'(a_out_valid), 32'd0);
        check_eq("rst_mag_a", 32'(a_out_mag), 32'd0);
        check_eq("rst_sumsq_b", 32'(b_out_sumsq), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("idle_in_ready", 32'(a_in_ready), 32'd1);
        ena = 1'b0;
        #1;
        check_eq("ena0_in_ready", 32'(a_in_ready), 32'd0);
        ena = 1'b1;

        // Directed points
        run_vec(1'b0, 32'h0000_0403, 0, 0);   // (3,4) -> 5
        run_vec(1'b0, 32'h0000_FFFF, 0, 0);   // (255,255)
        run_vec(1'b0, 32'h0000_0000, 20, 0);  // zero, long back-pressure
        run_vec(1'b1, 32'h0000_FCFD, 0, 0);   // (-3,-4,0,0) -> 5
        run_vec(1'b1, 32'h8080_8080, 2, 0);   // four x -128
        run_vec(1'b1, 32'h7F7F_7F7F, 0, 3);   // ena gaps mid-ROOT
        run_vec(1'b0, 32'h0000_FFFF, 1, 2);

        // Randomised
        for (int i = 0; i < 40; i++) begin
            run_vec(1'(i & 1), $urandom, $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        // Reset during ROOT aborts; the partial result never appears.
        run_vec(1'b0, 32'h0000_6464, 0, 0);   // leaves nonzero out_mag
        @(negedge clk);
        cur_sel    = 1'b0;
        in_data_v  = 32'h0000_64C8;
        in_valid_v = 1'b1;
        @(negedge clk);
        in_valid_v = 1'b0;
        nch_r = 2;
        repeat (nch_r + 3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_valid", 32'(a_out_valid), 32'd0);
        check_eq("abort_mag", 32'(a_out_mag), 32'd0);
        check_eq("abort_sumsq", 32'(a_out_sumsq), 32'd0);
        check_eq("abort_in_ready", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(1'b0, 32'h0000_0806, 0, 0);   // (6,8) -> 10

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
